oms_lut_loader: RTL and testbench

OMS_LUT_LOADER -- requirements
Module: oms_lut_loader

---
 rtl/oms_lut_loader_pkg.sv | 25 ++
 rtl/oms_shadow_ram.sv | 29 ++
 rtl/oms_lut_loader.sv | 146 ++++++++++++++
 tb/tb_oms_lut_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oms_lut_loader_pkg.sv
// Shared types, sizes and the odd-multiple coefficient helper for the LUT loader.
// The VERIFY state only exists when OMS_LOADER_VERIFY_EN is defined.
package oms_lut_loader_pkg;

  localparam int LUT_DEPTH = 9;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 9;
  localparam int A_W       = 5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LUT_DEPTH - 1);

`ifdef OMS_LOADER_VERIFY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;
`endif

  // Entry k holds (2k-1)*a, except entry 0 which holds 0.
  function automatic logic [ADDR_W-1:0] odd_coef(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W:0] twice_minus_one;
    twice_minus_one = {idx, 1'b0} - (ADDR_W+1)'(1);
    return (idx == '0) ? '0 : twice_minus_one[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/oms_shadow_ram.sv
// Shadow copy of the external LUT: one write port and one combinational read port.
// The whole table is cleared by reset; out-of-range reads return 0.
module oms_shadow_ram
  import oms_lut_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [LUT_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i <= LAST_IDX)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i <= LAST_IDX) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/oms_lut_loader.sv
// Loads a 9-entry odd-multiple table (0, a, 3a, ... 15a) into an external LUT and a shadow copy.
// Optional read-back check of the shadow copy is enabled by defining OMS_LOADER_VERIFY_EN.
module oms_lut_loader
  import oms_lut_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [A_W-1:0]    a,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              table_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [A_W-1:0]    a_q, a_d;
  logic              tv_q, tv_d;
  logic [DATA_W-1:0] a_x2;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

`ifdef OMS_LOADER_VERIFY_EN
  logic              err_q, err_d;
  logic [DATA_W-1:0] verify_exp;

  assign verify_exp = DATA_W'(odd_coef(idx_q)) * DATA_W'(a_q);
  assign ram_raddr  = (state_q == ST_VERIFY) ? idx_q : rd_addr;
  assign err        = err_q;
`else
  assign ram_raddr  = rd_addr;
  assign err        = 1'b0;
`endif

  assign a_x2 = DATA_W'({a_q, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      tv_q    <= 1'b0;
`ifdef OMS_LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      tv_q    <= tv_d;
`ifdef OMS_LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  // After idx 0 (zero) and idx 1 (a), each odd multiple is the previous one plus 2a.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    a_d     = a_q;
    tv_d    = tv_q;
`ifdef OMS_LOADER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          idx_d   = '0;
          acc_d   = '0;
          tv_d    = 1'b0;
`ifdef OMS_LOADER_VERIFY_EN
          err_d   = 1'b0;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        acc_d = (idx_q == '0) ? DATA_W'(a_q) : acc_q + a_x2;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
`ifdef OMS_LOADER_VERIFY_EN
          state_d = ST_VERIFY;
`else
          tv_d    = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef OMS_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (ram_rdata != verify_exp) begin
          err_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          tv_d    = ~err_d;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en       = (state_q == ST_LOAD);
    wr_addr     = wr_en ? idx_q : '0;
    wr_data     = wr_en ? acc_q : '0;
`ifdef OMS_LOADER_VERIFY_EN
    busy        = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
`else
    busy        = (state_q == ST_LOAD);
`endif
    done        = (state_q == ST_DONE);
    table_valid = tv_q;
    rd_data     = tv_q ? ram_rdata : '0;
  end

  oms_shadow_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_oms_lut_loader.sv
// Scoreboard bench for oms_lut_loader: expected LUT writes are queued at start and popped as writes appear.
// Define OMS_LOADER_VERIFY_EN to also exercise the read-back check.
module tb_oms_lut_loader;
  import oms_lut_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [A_W-1:0]    a = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              table_valid;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  asserts = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_count = 0;

`ifdef OMS_LOADER_VERIFY_EN
  localparam int DONE_OFS = 18;
`else
  localparam int DONE_OFS = 9;
`endif

  oms_lut_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write scoreboard and done-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      asserts++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
          fails++;
          $display("[TB] FAIL lut_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (rst_n && done) done_count++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Queue the nine expected words, pulse start; returns the accepting edge count in n.
  task automatic start_load(input int av, output int n);
    @(negedge clk);
    a = A_W'(av);
    start = 1'b1;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      wr_t e;
      e.addr = ADDR_W'(k);
      e.data = (k == 0) ? '0 : DATA_W'((2 * k - 1) * av);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, wr_en, table_valid, err, wr_addr, wr_data} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b wr_en=%b tv=%b err=%b addr=%0d data=%0d, required all 0",
               busy, done, wr_en, table_valid, err, wr_addr, wr_data);
    end
    do_reset();
    asserts++;
    if (rd_data !== '0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_idle: got rd_data=%0d busy=%b, required 0 0", rd_data, busy);
    end
  endtask

  task automatic test_a5();
    int n, dcyc;
    bit ok;
    start_load(5, n);
    wait_done(dcyc, ok);
    asserts++;
    if (!ok || dcyc != n + DONE_OFS) begin
      fails++;
      $display("[TB] FAIL a5_done_latency: got edge offset %0d (seen=%b), required %0d", dcyc - n, ok, DONE_OFS);
    end
    asserts++;
    if (table_valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL a5_done_flags: got tv=%b busy=%b err=%b, required 1 0 0", table_valid, busy, err);
    end
    asserts++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL a5_write_count: got %0d words missing, required 0", exp_q.size());
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL a5_done_pulse: got done=%b one cycle later, required 0", done);
    end
    rd_addr = 4'd3;
    #1;
    asserts++;
    if (rd_data !== 9'd25) begin
      fails++;
      $display("[TB] FAIL a5_read3: got %0d, required 25", rd_data);
    end
    rd_addr = 4'd9;
    #1;
    asserts++;
    if (rd_data !== 9'd0) begin
      fails++;
      $display("[TB] FAIL a5_read9: got %0d, required 0", rd_data);
    end
  endtask

  task automatic test_extremes();
    int n, dcyc;
    bit ok;
    start_load(31, n);
    wait_done(dcyc, ok);
    rd_addr = 4'd8;
    #1;
    asserts++;
    if (!ok || rd_data !== 9'd465) begin
      fails++;
      $display("[TB] FAIL a31_read8: got %0d (done seen=%b), required 465", rd_data, ok);
    end
    start_load(0, n);
    wait_done(dcyc, ok);
    asserts++;
    if (!ok || table_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL a0_done: got done seen=%b tv=%b, required 1 1", ok, table_valid);
    end
    for (int k = 0; k < LUT_DEPTH; k++) begin
      rd_addr = ADDR_W'(k);
      #1;
      asserts++;
      if (rd_data !== 9'd0) begin
        fails++;
        $display("[TB] FAIL a0_read%0d: got %0d, required 0", k, rd_data);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int n, dcyc, dc0;
    bit ok;
    dc0 = done_count;
    start_load(5, n);
    while (cyc < n + 3) @(negedge clk);
    start = 1'b1;
    a = 5'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(dcyc, ok);
    asserts++;
    if (!ok || dcyc != n + DONE_OFS) begin
      fails++;
      $display("[TB] FAIL restart_done_latency: got edge offset %0d (seen=%b), required %0d", dcyc - n, ok, DONE_OFS);
    end
    start = 1'b1;
    @(negedge clk);
    asserts++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL start_in_done: got busy=%b after start during DONE, required 0", busy);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    asserts++;
    if (done_count - dc0 != 1) begin
      fails++;
      $display("[TB] FAIL restart_done_count: got %0d done pulses, required 1", done_count - dc0);
    end
    rd_addr = 4'd8;
    #1;
    asserts++;
    if (rd_data !== 9'd75) begin
      fails++;
      $display("[TB] FAIL restart_read8: got %0d, required 75", rd_data);
    end
  endtask

  task automatic test_reset_midload();
    int n, dc0;
    dc0 = done_count;
    start_load(4, n);
    while (cyc < n + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, wr_en, table_valid, err, wr_addr, wr_data} !== '0) begin
      fails++;
      $display("[TB] FAIL midload_reset: got busy=%b done=%b wr_en=%b tv=%b addr=%0d data=%0d, required all 0",
               busy, done, wr_en, table_valid, wr_addr, wr_data);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    asserts++;
    if (done_count != dc0 || table_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midload_no_done: got %0d done pulses tv=%b, required 0 0", done_count - dc0, table_valid);
    end
    for (int k = 0; k < 16; k++) begin
      rd_addr = ADDR_W'(k);
      #1;
      asserts++;
      if (rd_data !== 9'd0) begin
        fails++;
        $display("[TB] FAIL midload_read%0d: got %0d, required 0", k, rd_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, dcyc;
    bit ok;
    start_load(3, n);
    wait_done(dcyc, ok);
    asserts++;
    if (!ok || table_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_first: got done seen=%b tv=%b, required 1 1", ok, table_valid);
    end
    start_load(9, n);
    asserts++;
    if (table_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_second_start: got tv=%b busy=%b, required 0 1", table_valid, busy);
    end
    wait_done(dcyc, ok);
    rd_addr = 4'd8;
    #1;
    asserts++;
    if (!ok || rd_data !== 9'd135) begin
      fails++;
      $display("[TB] FAIL b2b_read8: got %0d (done seen=%b), required 135", rd_data, ok);
    end
  endtask

`ifdef OMS_LOADER_VERIFY_EN
  task automatic test_verify_corrupt();
    int n, dcyc;
    bit ok;
    start_load(6, n);
    while (cyc < n + 9) @(negedge clk);
    force dut.u_ram.mem_q[4] = 9'd1;
    wait_done(dcyc, ok);
    asserts++;
    if (!ok || dcyc != n + 18) begin
      fails++;
      $display("[TB] FAIL verify_done_latency: got edge offset %0d (seen=%b), required 18", dcyc - n, ok);
    end
    asserts++;
    if (err !== 1'b1 || table_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL verify_err: got err=%b tv=%b, required 1 0", err, table_valid);
    end
    release dut.u_ram.mem_q[4];
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_a5();
    test_extremes();
    test_restart_ignored();
    test_reset_midload();
    test_back_to_back();
`ifdef OMS_LOADER_VERIFY_EN
    test_verify_corrupt();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
